pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports imem_read in 1 (fetch request active) and imem_resp in 1 (fetch data valid this cycle).
REQ-004 SHALL have ports dmem_req in 1 (EX/MEM stage data access active) and dmem_resp in 1 (data access completes this cycle).
REQ-005 SHALL have ports idex_mem_read in 1 and idex_dest in 3: ID/EX holds a load and its destination register.
REQ-006 SHALL have ports ifid_src1 in 3, ifid_src2 in 3, ifid_uses_src1 in 1, ifid_uses_src2 in 1: IF/ID source registers and their use flags.
REQ-007 SHALL have ports br_taken in 1 and br_target in 16: taken control transfer resolved in EX/MEM, with its target.
REQ-008 SHALL have ports load_pc out 1, pc_redirect out 1 (PC mux selects redirect_pc) and redirect_pc out 16.
REQ-009 SHALL have ports ifid_load, idex_load, exme_load, mewb_load, each out 1: stage register load enables.
REQ-010 SHALL have ports ifid_clear, idex_clear, exme_clear, mewb_clear, each out 1: stage register synchronous clear (bubble); clear takes priority over load.
REQ-011 SHALL have ports stall_cycles out 16 and flush_count out 16 (performance counters, see Configuration).

Function
REQ-012 SHALL define imiss = imem_read & ~imem_resp, dmiss = dmem_req & ~dmem_resp, luh = idex_mem_read & ((ifid_uses_src1 & ifid_src1==idex_dest) | (ifid_uses_src2 & ifid_src2==idex_dest)); R0 is not exempt.
REQ-013 SHALL implement two states: RUN, DRAIN (redirect pending; in-flight fetch must complete before PC changes).
REQ-014 SHALL drive all outputs combinationally from state, held target and current inputs; zero added latency.
REQ-015 RUN priority 1, dmiss: load_pc, ifid_load, idex_load, exme_load = 0; mewb_clear = 1 (one WB bubble per stall cycle); br_taken ignored.
REQ-016 RUN priority 2, br_taken & ~imiss: load_pc = 1, pc_redirect = 1, redirect_pc = br_target; ifid_clear, idex_clear, exme_clear = 1; mewb_load = 1; stay RUN.
REQ-017 RUN priority 2, br_taken & imiss: capture br_target into target register; load_pc = 0; ifid_clear, idex_clear, exme_clear = 1; mewb_load = 1; next state DRAIN.
REQ-018 RUN priority 3, luh: load_pc = 0, ifid_load = 0, idex_clear = 1, exme_load = mewb_load = 1.
REQ-019 RUN priority 4, imiss: load_pc = 0, ifid_load = 0, idex_clear = 1, exme_load = mewb_load = 1.
REQ-020 RUN otherwise: load_pc and all four stage loads = 1, all clears = 0, pc_redirect = 0.
REQ-021 DRAIN: ifid_clear = idex_clear = 1 every cycle; br_taken and luh ignored; exme/mewb follow REQ-015 if dmiss, else load normally.
REQ-022 DRAIN with imem_resp = 1: load_pc = 1, pc_redirect = 1, redirect_pc = target register, next state RUN, independent of dmiss.
REQ-023 redirect_pc SHALL equal br_target whenever state is RUN; pc_redirect = 0 whenever load_pc = 0.

Reset
REQ-024 While reset = 0: state RUN, target register 0x0000, counters 0x0000, load_pc and all *_load = 0, all *_clear = 1, pc_redirect = 0.
REQ-025 Reset asserted mid-DRAIN SHALL discard the pending redirect; first cycle after release is RUN.

Configuration
REQ-026 Macro PIPE_CTRL_PERF_EN defined: stall_cycles increments each cycle load_pc = 0 out of reset; flush_count increments each cycle pc_redirect = 1; both saturate at 0xFFFF.
REQ-027 Macro PIPE_CTRL_PERF_EN undefined: counter registers not built; stall_cycles and flush_count tied to 0x0000; all other behaviour identical.

Verification
REQ-028 Release reset, imem_resp = 1 every cycle, no hazards -> all loads = 1, clears = 0 every cycle; counters stay 0.
REQ-029 idex_mem_read = 1, idex_dest = 3, ifid_src1 = 3, ifid_uses_src1 = 1 for one cycle -> load_pc = 0, ifid_load = 0, idex_clear = 1 that cycle only; stall_cycles = 1.
REQ-030 dmem_req = 1, dmem_resp low for 3 cycles then high -> 3 cycles of pipe frozen with mewb_clear = 1; all loads 1 on resp cycle.
REQ-031 br_taken = 1, br_target = 0x3000, imem_resp = 1 -> same cycle redirect_pc = 0x3000, pc_redirect = 1, ifid/idex/exme_clear = 1; flush_count = 1.
REQ-032 br_taken = 1, br_target = 0x1234 with imem_resp low; br_taken drops; imem_resp high 2 cycles later -> DRAIN 2 cycles, then redirect_pc = 0x1234, pc_redirect = 1, back to RUN.
REQ-033 Reset pulsed low during DRAIN (target 0x1234) -> after release no redirect issued; state RUN; counters 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- pipeline hazard/control bundle between the datapath and
// the pipe_ctrl hazard controller.
//
// Signals (direction as seen by the controller, modport slave):
//   in : imem_read, imem_resp            fetch request / fetch data valid
//   in : dmem_req, dmem_resp             EX/MEM data access / completion
//   in : idex_mem_read, idex_dest[2:0]   load sitting in ID/EX and its dest
//   in : ifid_src1/2[2:0], ifid_uses_src1/2  IF/ID sources and use flags
//   in : br_taken, br_target[15:0]       taken transfer resolved in EX/MEM
//   out: load_pc, pc_redirect, redirect_pc[15:0]
//   out: ifid/idex/exme/mewb _load, _clear   stage enables (clear wins)
//   out: stall_cycles[15:0], flush_count[15:0] performance counters
// modport master is the datapath side, modport slave the controller.
interface pipe_ctrl_if;
    logic        imem_read;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        idex_mem_read;
    logic [2:0]  idex_dest;
    logic [2:0]  ifid_src1;
    logic [2:0]  ifid_src2;
    logic        ifid_uses_src1;
    logic        ifid_uses_src2;
    logic        br_taken;
    logic [15:0] br_target;
    logic        load_pc;
    logic        pc_redirect;
    logic [15:0] redirect_pc;
    logic        ifid_load;
    logic        idex_load;
    logic        exme_load;
    logic        mewb_load;
    logic        ifid_clear;
    logic        idex_clear;
    logic        exme_clear;
    logic        mewb_clear;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output imem_read, imem_resp, dmem_req, dmem_resp,
               idex_mem_read, idex_dest, ifid_src1, ifid_src2,
               ifid_uses_src1, ifid_uses_src2, br_taken, br_target,
        input  load_pc, pc_redirect, redirect_pc,
               ifid_load, idex_load, exme_load, mewb_load,
               ifid_clear, idex_clear, exme_clear, mewb_clear,
               stall_cycles, flush_count
    );

    modport slave (
        input  imem_read, imem_resp, dmem_req, dmem_resp,
               idex_mem_read, idex_dest, ifid_src1, ifid_src2,
               ifid_uses_src1, ifid_uses_src2, br_taken, br_target,
        output load_pc, pc_redirect, redirect_pc,
               ifid_load, idex_load, exme_load, mewb_load,
               ifid_clear, idex_clear, exme_clear, mewb_clear,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard and redirect controller for a 4-register pipeline.
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pipe_ctrl_if.slave (hazard inputs, PC/stage controls, counters)
//
// States: RUN, DRAIN (a taken branch arrived while a fetch was still
// outstanding; the target is held until the fetch returns, then redirected).
// All outputs are combinational from state, held target and current inputs.
//
// Build option: define PIPE_CTRL_PERF_EN to build the saturating
// stall_cycles / flush_count counters; otherwise both read as zero.
module pipe_ctrl (
    input logic      clk,
    input logic      reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] target_q, target_d;

    logic imiss, dmiss, luh;
    logic load_pc, pc_redirect;
    logic [15:0] redirect_pc;
    logic ifid_load, idex_load, exme_load, mewb_load;
    logic ifid_clear, idex_clear, exme_clear, mewb_clear;

    // R0 takes part in the load-use compare like any other register.
    assign imiss = bus.imem_read & ~bus.imem_resp;
    assign dmiss = bus.dmem_req & ~bus.dmem_resp;
    assign luh   = bus.idex_mem_read &
                   ((bus.ifid_uses_src1 & (bus.ifid_src1 == bus.idex_dest)) |
                    (bus.ifid_uses_src2 & (bus.ifid_src2 == bus.idex_dest)));

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        load_pc     = 1'b1;
        pc_redirect = 1'b0;
        redirect_pc = (state_q == ST_DRAIN) ? target_q : bus.br_target;
        ifid_load   = 1'b1;
        idex_load   = 1'b1;
        exme_load   = 1'b1;
        mewb_load   = 1'b1;
        ifid_clear  = 1'b0;
        idex_clear  = 1'b0;
        exme_clear  = 1'b0;
        mewb_clear  = 1'b0;

        if (!reset) begin
            load_pc    = 1'b0;
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exme_load  = 1'b0;
            mewb_load  = 1'b0;
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
            exme_clear = 1'b1;
            mewb_clear = 1'b1;
        end else if (state_q == ST_DRAIN) begin
            // Younger stages hold wrong-path work until the redirect lands.
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
            if (dmiss) begin
                exme_load  = 1'b0;
                mewb_clear = 1'b1;
            end
            if (bus.imem_resp) begin
                pc_redirect = 1'b1;
                state_d     = ST_RUN;
            end else begin
                load_pc = 1'b0;
            end
        end else begin
            if (dmiss) begin
                // Whole pipe frozen; WB gets a bubble each stalled cycle.
                load_pc    = 1'b0;
                ifid_load  = 1'b0;
                idex_load  = 1'b0;
                exme_load  = 1'b0;
                mewb_clear = 1'b1;
            end else if (bus.br_taken) begin
                ifid_clear = 1'b1;
                idex_clear = 1'b1;
                exme_clear = 1'b1;
                if (imiss) begin
                    load_pc  = 1'b0;
                    target_d = bus.br_target;
                    state_d  = ST_DRAIN;
                end else begin
                    pc_redirect = 1'b1;
                end
            end else if (luh || imiss) begin
                load_pc    = 1'b0;
                ifid_load  = 1'b0;
                idex_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!load_pc && stall_q != '1)
                stall_q <= stall_q + 16'd1;
            if (pc_redirect && flush_q != '1)
                flush_q <= flush_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

    assign bus.load_pc     = load_pc;
    assign bus.pc_redirect = pc_redirect;
    assign bus.redirect_pc = redirect_pc;
    assign bus.ifid_load   = ifid_load;
    assign bus.idex_load   = idex_load;
    assign bus.exme_load   = exme_load;
    assign bus.mewb_load   = mewb_load;
    assign bus.ifid_clear  = ifid_clear;
    assign bus.idex_clear  = idex_clear;
    assign bus.exme_clear  = exme_clear;
    assign bus.mewb_clear  = mewb_clear;
endmodule
